// File: rtl/key_decoder_if.sv
// key_decoder_if: switch/button inputs and octave/note outputs of the key decoder
interface key_decoder_if;
    logic [6:0] sw;
    logic       btn_up;
    logic       btn_down;
    logic [2:0] octave;
    logic [2:0] note;
    logic       note_changed;
    modport master (output sw, btn_up, btn_down, input octave, note, note_changed);
    modport slave  (input sw, btn_up, btn_down, output octave, note, note_changed);
endinterface

// File: rtl/key_decoder.sv
// key_decoder: synchronizes/debounces note switches and octave buttons, tracks octave, encodes note.
// Define KEY_DECODER_OCTAVE_WRAP_EN to make the octave wrap instead of saturating at 0/7.
module key_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int OCTAVE_RESET    = 4
) (
    input logic          clk,
    input logic          rst_n,
    key_decoder_if.slave kif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, HELD} state_t;

    logic [8:0]    raw, s1, s2, db;
    logic [CW-1:0] cnt [9];
    state_t        state;
    logic [2:0]    octave_q, note_q, oct_nxt, note_nxt;
    logic          changed_q, up, dn;

    assign raw = {kif.btn_down, kif.btn_up, kif.sw};
    assign up  = db[7];
    assign dn  = db[8];

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive mismatching samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < 9; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 9; i++) begin
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == CMAX) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    always_comb begin
        note_nxt = '0;
        for (int i = 6; i >= 0; i--) if (db[i]) note_nxt = 3'(i + 1);
    end

    always_comb begin
`ifdef KEY_DECODER_OCTAVE_WRAP_EN
        oct_nxt = (state == IDLE && up && !dn) ? octave_q + 3'd1 :
                  (state == IDLE && dn && !up) ? octave_q - 3'd1 : octave_q;
`else
        oct_nxt = (state == IDLE && up && !dn && octave_q != 3'd7) ? octave_q + 3'd1 :
                  (state == IDLE && dn && !up && octave_q != 3'd0) ? octave_q - 3'd1 : octave_q;
`endif
    end

    // In IDLE a high debounced button is necessarily a fresh rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            octave_q  <= 3'(OCTAVE_RESET);
            note_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            state     <= (up || dn) ? HELD : IDLE;
            octave_q  <= oct_nxt;
            note_q    <= note_nxt;
            changed_q <= (oct_nxt != octave_q) || (note_nxt != note_q);
        end
    end

    assign kif.octave       = octave_q;
    assign kif.note         = note_q;
    assign kif.note_changed = changed_q;
endmodule

// File: tb/tb_key_decoder.sv
// tb_key_decoder: sliding-window debounce model checked every cycle, plus directed literal checks.
module tb_key_decoder;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    key_decoder_if kif ();

    key_decoder #(.DEBOUNCE_CYCLES(DC), .OCTAVE_RESET(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kif  (kif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an input's accepted level changes once the last DC synchronized samples all disagree with it
    logic [8:0] hist [0:DC+1];
    logic [8:0] mdb;
    int         m_oct, m_note;
    bit         m_held, m_nc;

    always @(posedge clk or negedge rst_n) begin
        int  n, o;
        bit  same;
        if (!rst_n) begin
            for (int i = 0; i <= DC + 1; i++) hist[i] = '0;
            mdb = '0; m_oct = 4; m_note = 0; m_nc = 0; m_held = 0;
        end else begin
            n = 0;
            for (int i = 6; i >= 0; i--) if (mdb[i]) n = i + 1;
            o = m_oct;
            if (!m_held && mdb[7] && !mdb[8])
`ifdef KEY_DECODER_OCTAVE_WRAP_EN
                o = (m_oct + 1) % 8;
`else
                o = (m_oct < 7) ? m_oct + 1 : 7;
`endif
            if (!m_held && mdb[8] && !mdb[7])
`ifdef KEY_DECODER_OCTAVE_WRAP_EN
                o = (m_oct + 7) % 8;
`else
                o = (m_oct > 0) ? m_oct - 1 : 0;
`endif
            m_held = mdb[7] | mdb[8];
            m_nc   = (n != m_note) || (o != m_oct);
            m_note = n;
            m_oct  = o;
            for (int i = DC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {kif.btn_down, kif.btn_up, kif.sw};
            for (int b = 0; b < 9; b++) begin
                same = 1;
                for (int j = 2; j <= DC + 1; j++) if (hist[j][b] != hist[2][b]) same = 0;
                if (same) mdb[b] = hist[2][b];
            end
        end
    end

    always @(negedge clk) begin
        chk("model_octave", int'(kif.octave), m_oct);
        chk("model_note", int'(kif.note), m_note);
        chk("model_note_changed", int'(kif.note_changed), int'(m_nc));
    end

    task automatic wait_cnt(input int n, inout int p);
        repeat (n) begin
            @(negedge clk);
            p += int'(kif.note_changed);
        end
    endtask

    int p;
`ifdef KEY_DECODER_OCTAVE_WRAP_EN
    int exp_oct [3] = '{6, 7, 0};
    int exp_pul [3] = '{1, 1, 1};
    int lim_oct = 0, dn_oct = 7;
`else
    int exp_oct [3] = '{6, 7, 7};
    int exp_pul [3] = '{1, 1, 0};
    int lim_oct = 7, dn_oct = 6;
`endif

    initial begin
        kif.sw = '0; kif.btn_up = 1'b0; kif.btn_down = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_octave", int'(kif.octave), 4);
        chk("reset_note", int'(kif.note), 0);
        chk("reset_note_changed", int'(kif.note_changed), 0);
        // sw[2] held: note=3 exactly DC+3 edges later
        kif.sw = 7'b0000100;
        repeat (6) @(negedge clk);
        chk("e_early_note", int'(kif.note), 0);
        @(negedge clk);
        chk("e_note", int'(kif.note), 3);
        chk("e_pulse", int'(kif.note_changed), 1);
        @(negedge clk);
        chk("e_pulse_end", int'(kif.note_changed), 0);
        kif.sw = '0;
        repeat (12) @(negedge clk);
        chk("e_release", int'(kif.note), 0);
        // 3-cycle glitch on sw[0] is rejected
        p = 0;
        kif.sw = 7'b0000001;
        wait_cnt(3, p);
        kif.sw = '0;
        wait_cnt(12, p);
        chk("glitch_pulses", p, 0);
        chk("glitch_note", int'(kif.note), 0);
        // priority: sw[1] beats sw[4]
        kif.sw = 7'b0010010;
        repeat (10) @(negedge clk);
        chk("prio_note", int'(kif.note), 2);
        kif.sw = 7'b0010000;
        repeat (6) @(negedge clk);
        chk("prio_early", int'(kif.note), 2);
        @(negedge clk);
        chk("prio_g", int'(kif.note), 5);
        kif.sw = '0;
        repeat (10) @(negedge clk);
        // held button gives one step
        kif.btn_up = 1'b1;
        repeat (50) @(negedge clk);
        chk("hold_octave", int'(kif.octave), 5);
        kif.btn_up = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            p = 0;
            kif.btn_up = 1'b1;
            wait_cnt(10, p);
            kif.btn_up = 1'b0;
            wait_cnt(10, p);
            chk("press_octave", int'(kif.octave), exp_oct[k]);
            chk("press_pulses", p, exp_pul[k]);
        end
        // both buttons together: no step, stays held until both released
        kif.btn_up = 1'b1; kif.btn_down = 1'b1;
        repeat (10) @(negedge clk);
        chk("both_octave", int'(kif.octave), lim_oct);
        kif.btn_up = 1'b0;
        repeat (10) @(negedge clk);
        chk("both_down_held", int'(kif.octave), lim_oct);
        kif.btn_down = 1'b0;
        repeat (10) @(negedge clk);
        chk("both_released", int'(kif.octave), lim_oct);
        kif.btn_down = 1'b1;
        repeat (10) @(negedge clk);
        kif.btn_down = 1'b0;
        repeat (10) @(negedge clk);
        chk("down_octave", int'(kif.octave), dn_oct);
        // async reset mid-qualification
        kif.sw = 7'b0001000;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_octave", int'(kif.octave), 4);
        chk("areset_note", int'(kif.note), 0);
        chk("areset_note_changed", int'(kif.note_changed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("requal_early", int'(kif.note), 0);
        @(negedge clk);
        chk("requal_note", int'(kif.note), 4);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
